// File: rtl/led_ui_pkg.sv
// Shared types and timing constants for the LED user-interface blocks.
package led_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } blink_state_e;

    localparam int unsigned CLK_HZ = 10_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned BLINK_ON_CYCLES  = ms_to_cycles(200);
    localparam int unsigned BLINK_OFF_CYCLES = ms_to_cycles(200);

endpackage

// File: rtl/blink_timer.sv
// Phase down-counter: loads a value, counts down to zero and holds there.
module blink_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturate at zero so an idle timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_blink_reporter.sv
// Emits `count` LED blinks on request, then a one-cycle done pulse.
module led_blink_reporter
    import led_ui_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = BLINK_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = BLINK_OFF_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] count,
    output logic       ready,
    output logic       done,
    output logic       led_out
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    // Timer runs N-1 .. 0, so a phase lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

    blink_state_e       state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               led_q, led_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               timer_load_c;
    logic [TIMER_W-1:0] timer_val_c;
    logic               timer_zero;

    blink_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .zero     (timer_zero)
    );

    // Next state, counter update and timer reload on each phase entry.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        timer_load_c = 1'b0;
        timer_val_c  = ON_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = count;
                    if (count != '0) begin
                        state_d      = ST_ON;
                        timer_load_c = 1'b1;
                        timer_val_c  = ON_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ON: begin
                if (timer_zero) begin
                    state_d      = ST_OFF;
                    timer_load_c = 1'b1;
                    timer_val_c  = OFF_LOAD;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (timer_zero) begin
                    if (remaining_q != '0) begin
                        state_d      = ST_ON;
                        timer_load_c = 1'b1;
                        timer_val_c  = ON_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs decoded from the next state so they are pure flops.
        led_d   = (state_d == ST_ON);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            led_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign led_out = led_q;
    assign ready   = ready_q;
    assign done    = done_q;

endmodule

// File: tb/tb_led_blink_reporter.sv
// Directed bench for led_blink_reporter with ON_CYCLES=4, OFF_CYCLES=3.
module tb_led_blink_reporter;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 3;
    localparam int unsigned PER   = ON_C + OFF_C;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       ready;
    logic       done;
    logic       led_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rises;

    led_blink_reporter #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .count   (count),
        .ready   (ready),
        .done    (done),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; acceptance happens on the next posedge.
    task automatic accept(input logic [3:0] c);
        check("ready_before_accept", 32'(ready), 32'd1);
        start = 1'b1;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks cycles T+1..T+len after acceptance; optionally pokes a new request at inj_k.
    task automatic follow(input int unsigned c, input int unsigned len, input string name,
                          input int unsigned inj_k, input logic [3:0] inj_c,
                          input bit hold, output int unsigned n_rise);
        logic        prev;
        bit          e_led;
        bit          e_done;
        bit          e_ready;
        int unsigned body;
        prev   = 1'b0;
        n_rise = 0;
        body   = c * PER;
        for (int unsigned k = 1; k <= len; k++) begin
            e_led   = (k <= body) && (((k - 1) % PER) < ON_C);
            e_done  = (k == body + 1);
            e_ready = (k >= body + 2);
            check($sformatf("%s_led@T+%0d", name, k), 32'(led_out), 32'(e_led));
            check($sformatf("%s_done@T+%0d", name, k), 32'(done), 32'(e_done));
            check($sformatf("%s_ready@T+%0d", name, k), 32'(ready), 32'(e_ready));
            if (led_out === 1'b1 && prev === 1'b0) n_rise++;
            prev = led_out;
            if (!hold) begin
                if (k == inj_k) begin
                    start = 1'b1;
                    count = inj_c;
                end else begin
                    start = 1'b0;
                end
            end
            if (k < len) @(negedge clk);
        end
    endtask

    initial begin
        // Reset state, checked while clock runs with rst_n low.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("idle_ready@%0d", i), 32'(ready), 32'd1);
            check($sformatf("idle_led@%0d", i), 32'(led_out), 32'd0);
            check($sformatf("idle_done@%0d", i), 32'(done), 32'd0);
        end

        accept(4'd3);
        follow(3, 23, "c3", 0, 4'd0, 1'b0, rises);
        check("c3_rises", rises, 32'd3);

        accept(4'd0);
        follow(0, 2, "c0", 0, 4'd0, 1'b0, rises);
        check("c0_rises", rises, 32'd0);

        accept(4'd2);
        follow(2, 16, "c2_ignore", 5, 4'd9, 1'b0, rises);
        check("c2_rises", rises, 32'd2);

        accept(4'd15);
        follow(15, 107, "c15", 0, 4'd0, 1'b0, rises);
        check("c15_rises", rises, 32'd15);

        // Start held high: two back-to-back reports with one idle cycle between.
        start = 1'b1;
        count = 4'd1;
        @(negedge clk);
        follow(1, 9, "hold_a", 0, 4'd0, 1'b1, rises);
        @(negedge clk);
        start = 1'b0;
        follow(1, 9, "hold_b", 0, 4'd0, 1'b0, rises);

        // Reset in the middle of a count=5 report.
        accept(4'd5);
        follow(5, 6, "abort", 0, 4'd0, 1'b0, rises);
        rst_n = 1'b0;
        #1;
        check("abort_led", 32'(led_out), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", 32'(done), 32'd0);
            check("abort_hold_led", 32'(led_out), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("post_abort_done@%0d", i), 32'(done), 32'd0);
            check($sformatf("post_abort_led@%0d", i), 32'(led_out), 32'd0);
        end
        accept(4'd1);
        follow(1, 9, "after_rst", 0, 4'd0, 1'b0, rises);
        check("after_rst_rises", rises, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
